fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain adapter sitting directly downstream of the asynchronous FIFO, in the read clock domain. Pulls words from the FIFO's show-ahead read port (data valid while not empty, popped by `r_en`) and presents them as a valid/ready stream through a 2-entry skid buffer, so downstream backpressure never combinationally reaches the FIFO. Optionally frames the stream into fixed-length packets with a `last` marker, and supports a synchronous flush that drains and discards FIFO contents.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `PKT_LEN`, 8: beats per packet for `m_last`; legal range 1..256.
- `rclk`  in  1: read-domain clock, the single clock of the block.
- `rrst`  in  1: reset, synchronous, active-high.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH: FIFO head word; valid when `fifo_empty`=0.
- `fifo_r_en`  out  1: FIFO pop strobe.
- `flush`  in  1: level; drain FIFO and discard everything while high.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  DATA_WIDTH: output word.
- `m_last`  out  1: final beat of packet.

## Operation
- Storage: head register H, spare register S, occupancy `cnt` in {0,1,2}. `m_valid` = (`cnt`!=0); `m_data` = H.
- Pop rule: `fifo_r_en` = !`rrst` & !`fifo_empty` & (`cnt`!=2 | `flush`). Depends only on registered state, `fifo_empty`, `flush`, `rrst`; never on `m_ready`.
- Push = `fifo_r_en` & !`flush`; pop = `m_valid` & `m_ready`.
- Occupancy update (flush low): cnt 0 + push -> H=`fifo_data`, cnt 1. cnt 1 + push + pop -> H=`fifo_data`, cnt 1. cnt 1 + push only -> S=`fifo_data`, cnt 2. cnt 1 + pop only -> cnt 0. cnt 2 + pop -> H=S, cnt 1. No push is possible at cnt 2.
- Ordering: words leave in exactly FIFO order; no loss, no duplication.
- Flush: at every edge with `flush`=1, `cnt`<=0 and beat counter<=0; popped words are discarded; `m_valid` goes low the cycle after `flush` is first sampled. `m_ready` is ignored while `flush`=1.
- Beat counter `bcnt`, width max(1,$clog2(PKT_LEN)): increments on each accepted beat, wraps to 0 after PKT_LEN-1. `m_last` = `m_valid` & (`bcnt`==PKT_LEN-1). PKT_LEN=1: `m_last`=`m_valid`.
- Data registers H/S not reset beyond reset value; contents only meaningful under `m_valid`.

## Timing
- Reset (rrst sampled high): `cnt`=0, `bcnt`=0, H=S=0 -> `m_valid`=0, `m_data`=0, `m_last`=0; `fifo_r_en`=0 combinationally while `rrst`=1. Reset mid-packet discards buffered words and restarts framing at beat 0.
- Latency: word at FIFO head with `cnt`=0 is popped at edge N, `m_valid`=1 with that word from edge N to acceptance (1 cycle FIFO-to-output).
- Throughput: 1 word/cycle sustained with `fifo_empty`=0 and `m_ready`=1 (steady state `cnt`=1).
- Backpressure: `m_ready` low -> at most 2 words buffered, then `fifo_r_en`=0 until a beat is accepted; `m_valid`/`m_data`/`m_last` held stable while `m_valid`=1 & `m_ready`=0.
- `fifo_empty` is trusted as registered by the FIFO; it updates one cycle after a pop.

## Configuration
- `FIFO_RD_STREAM_LAST_EN` defined: beat counter and `m_last` generation as above.
- Not defined: beat counter removed, `m_last` tied 0; `PKT_LEN` ignored; all other behaviour identical.

## Test plan
- Reset: hold `rrst`=1 with `fifo_empty`=0 -> `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- Streaming: FIFO supplies 0x01..0x10, `m_ready`=1 -> first `m_valid` one cycle after first pop, 16 consecutive beats 0x01..0x10, `m_last` on 0x08 and 0x10 (PKT_LEN=8).
- Backpressure: `m_ready`=0 for 5 cycles with FIFO non-empty -> exactly 2 pops, `fifo_r_en`=0 afterwards, `m_data` held at first word; release -> remaining words in order, none lost.
- Empty gaps: `fifo_empty` toggled every other cycle, `m_ready`=1 -> output order preserved, `m_valid` drops only when `cnt`=0.
- Flush: after 3 beats of a packet, `flush`=1 for 4 cycles with 6 words in FIFO -> 4 pops discarded, `m_valid`=0 from the cycle after flush; next accepted word has beat 0 (`m_last` after 8 more beats).
- Macro off: repeat streaming test -> identical data, `m_last` never asserted.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Bundle of FIFO read-port, flush and output-stream signals for fifo_rd_stream.
// master: the adapter side; slave: the FIFO/downstream environment side.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_data, flush, m_ready,
    output fifo_r_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, flush, m_ready,
    input  fifo_r_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO read port into a valid/ready stream via a 2-entry skid buffer.
// Define FIFO_RD_STREAM_LAST_EN to enable PKT_LEN-beat framing on m_last.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_rd_stream_if.master bus
);
  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  occ_e                  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic                  valid;
  logic                  push;
  logic                  pop;

  // Pop decision uses only registered occupancy, so m_ready never reaches the FIFO.
  assign bus.fifo_r_en = !rrst && !bus.fifo_empty && ((cnt_q != OCC_2) || bus.flush);
  assign valid         = (cnt_q != OCC_0);
  assign push          = bus.fifo_r_en && !bus.flush;
  assign pop           = valid && bus.m_ready && !bus.flush;
  assign bus.m_valid   = valid;
  assign bus.m_data    = h_q;

  always_comb begin
    cnt_d = cnt_q;
    h_d   = h_q;
    s_d   = s_q;
    if (bus.flush) begin
      cnt_d = OCC_0;
    end else begin
      unique case (cnt_q)
        OCC_0: begin
          if (push) begin
            h_d   = bus.fifo_data;
            cnt_d = OCC_1;
          end
        end
        OCC_1: begin
          if (push && pop) begin
            h_d = bus.fifo_data;
          end else if (push) begin
            s_d   = bus.fifo_data;
            cnt_d = OCC_2;
          end else if (pop) begin
            cnt_d = OCC_0;
          end
        end
        OCC_2: begin
          if (pop) begin
            h_d   = s_q;
            cnt_d = OCC_1;
          end
        end
        default: cnt_d = OCC_0;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= OCC_0;
      h_q   <= '0;
      s_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      h_q   <= h_d;
      s_q   <= s_d;
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (bus.flush) begin
      bcnt_d = '0;
    end else if (pop) begin
      bcnt_d = (bcnt_q == LAST_BEAT) ? '0 : bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign bus.m_last = valid && (bcnt_q == LAST_BEAT);
`else
  assign bus.m_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a queue-backed show-ahead FIFO model.
module tb_fifo_rd_stream;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic rclk = 1'b0;
  logic rrst;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_stream #(
    .DATA_WIDTH(8),
    .PKT_LEN   (8)
  ) dut (
    .rclk(rclk),
    .rrst(rrst),
    .bus (bus)
  );

  always #5 rclk = ~rclk;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [7:0]  fq[$];
  bit          gap = 1'b0;
  int          popped = 0;
  int          exp_beat = 0;

  task automatic drive_fifo();
    bus.fifo_empty = gap || (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // One clock: sample the pop strobe before the edge, then retire the popped word.
  task automatic cycle();
    logic do_pop;
    do_pop = bus.fifo_r_en;
    @(posedge rclk);
    #1;
    if (do_pop && fq.size() != 0) begin
      void'(fq.pop_front());
      popped++;
    end
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    bus.flush = 1'b0;
    bus.m_ready = 1'b1;
    gap = 1'b0;
    fq = '{8'hAA, 8'hBB};
    drive_fifo();
    #1;
    vectors++;
    if (bus.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_r_en_comb: got %b expected 0", bus.fifo_r_en);
    end
    repeat (2) cycle();
    vectors++;
    if (bus.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_r_en: got %b expected 0", bus.fifo_r_en);
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid);
    end
    vectors++;
    if (bus.m_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_m_data: got %h expected 00", bus.m_data);
    end
    vectors++;
    if (bus.m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m_last: got %b expected 0", bus.m_last);
    end
    vectors++;
    if (fq.size() != 2) begin
      miscompares++;
      $display("FAIL reset_no_pop: got %0d words left expected 2", fq.size());
    end
    rrst = 1'b0;
    fq.delete();
    drive_fifo();
    exp_beat = 0;
    #1;
  endtask

  task automatic test_stream();
    int got = 0;
    int first = -1;
    int last = -1;
    bit exp_last;
    for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
    bus.m_ready = 1'b1;
    drive_fifo();
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.fifo_r_en !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_first_pop: got valid=%b r_en=%b expected valid=0 r_en=1", bus.m_valid, bus.fifo_r_en);
    end
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        exp_last = LAST_EN && (exp_beat == 7);
        vectors++;
        if (bus.m_data !== 8'(got + 1)) begin
          miscompares++;
          $display("FAIL stream_data: got %h expected %h", bus.m_data, 8'(got + 1));
        end
        vectors++;
        if (bus.m_last !== exp_last) begin
          miscompares++;
          $display("FAIL stream_last: beat %0d got %b expected %b", got, bus.m_last, exp_last);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        exp_beat = (exp_beat + 1) % 8;
      end
      cycle();
    end
    vectors++;
    if (got != 16) begin
      miscompares++;
      $display("FAIL stream_count: got %0d beats expected 16", got);
    end
    vectors++;
    if (first != 1) begin
      miscompares++;
      $display("FAIL stream_latency: first beat at cycle %0d expected 1", first);
    end
    vectors++;
    if (last - first != 15) begin
      miscompares++;
      $display("FAIL stream_throughput: span %0d expected 15", last - first);
    end
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drained: got valid=%b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    bit exp_last;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h21 + i));
    drive_fifo();
    #1;
    popped = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1) begin
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h21) begin
          miscompares++;
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h expected 1/21", c, bus.m_valid, bus.m_data);
        end
      end
      cycle();
    end
    vectors++;
    if (popped != 2) begin
      miscompares++;
      $display("FAIL bp_pops: got %0d expected 2", popped);
    end
    vectors++;
    if (bus.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_r_en: got %b expected 0", bus.fifo_r_en);
    end
    vectors++;
    if (bus.m_last !== (LAST_EN && exp_beat == 7)) begin
      miscompares++;
      $display("FAIL bp_last_hold: got %b expected %b", bus.m_last, LAST_EN && exp_beat == 7);
    end
    bus.m_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      if (bus.m_valid === 1'b1) begin
        exp_last = LAST_EN && (exp_beat == 7);
        vectors++;
        if (bus.m_data !== 8'(8'h21 + got) || bus.m_last !== exp_last) begin
          miscompares++;
          $display("FAIL bp_release: beat %0d got %h/%b expected %h/%b", got, bus.m_data, bus.m_last, 8'(8'h21 + got), exp_last);
        end
        got++;
        exp_beat = (exp_beat + 1) % 8;
      end
      cycle();
    end
    vectors++;
    if (got != 6 || fq.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats, %0d left expected 6, 0", got, fq.size());
    end
  endtask

  task automatic test_empty_gaps();
    int got = 0;
    bit exp_last;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h31 + i));
    for (int c = 0; c < 24 && got < 8; c++) begin
      gap = c[0];
      drive_fifo();
      #1;
      vectors++;
      if (bus.m_valid !== c[0]) begin
        miscompares++;
        $display("FAIL gap_valid: cycle %0d got %b expected %b", c, bus.m_valid, c[0]);
      end
      if (bus.m_valid === 1'b1) begin
        exp_last = LAST_EN && (exp_beat == 7);
        vectors++;
        if (bus.m_data !== 8'(8'h31 + got) || bus.m_last !== exp_last) begin
          miscompares++;
          $display("FAIL gap_data: beat %0d got %h/%b expected %h/%b", got, bus.m_data, bus.m_last, 8'(8'h31 + got), exp_last);
        end
        got++;
        exp_beat = (exp_beat + 1) % 8;
      end
      cycle();
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL gap_count: got %0d expected 8", got);
    end
    gap = 1'b0;
    drive_fifo();
    #1;
  endtask

  task automatic test_mid_reset();
    int got = 0;
    bit exp_last;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h71 + i));
    drive_fifo();
    #1;
    repeat (3) cycle();
    vectors++;
    if (bus.m_valid !== 1'b1 || fq.size() != 2) begin
      miscompares++;
      $display("FAIL mrst_fill: got valid=%b left=%0d expected 1, 2", bus.m_valid, fq.size());
    end
    rrst = 1'b1;
    #1;
    vectors++;
    if (bus.fifo_r_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_r_en: got %b expected 0", bus.fifo_r_en);
    end
    cycle();
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.m_last !== 1'b0 || fq.size() != 2) begin
      miscompares++;
      $display("FAIL mrst_clear: got %b/%h/%b left=%0d expected 0/00/0 left=2", bus.m_valid, bus.m_data, bus.m_last, fq.size());
    end
    rrst = 1'b0;
    exp_beat = 0;
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h75 + i));
    bus.m_ready = 1'b1;
    drive_fifo();
    #1;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      if (bus.m_valid === 1'b1) begin
        exp_last = LAST_EN && (got == 7);
        vectors++;
        if (bus.m_data !== 8'(8'h73 + got) || bus.m_last !== exp_last) begin
          miscompares++;
          $display("FAIL mrst_stream: beat %0d got %h/%b expected %h/%b", got, bus.m_data, bus.m_last, 8'(8'h73 + got), exp_last);
        end
        got++;
        exp_beat = (exp_beat + 1) % 8;
      end
      cycle();
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL mrst_count: got %0d expected 8", got);
    end
  endtask

  task automatic test_flush();
    int got = 0;
    bit exp_last;
    logic [7:0] exp_w;
    bus.m_ready = 1'b1;
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) fq.push_back(8'(8'h41 + i));
    for (int i = 0; i < 7; i++) fq.push_back(8'(8'h51 + i));
    drive_fifo();
    #1;
    for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
      if (bus.m_valid === 1'b1) begin
        vectors++;
        if (bus.m_data !== 8'(8'h41 + got) || bus.m_last !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_pre: beat %0d got %h/%b expected %h/0", got, bus.m_data, bus.m_last, 8'(8'h41 + got));
        end
        got++;
      end
      cycle();
    end
    vectors++;
    if (got != 3 || fq.size() != 6) begin
      miscompares++;
      $display("FAIL flush_setup: got %0d beats, %0d in fifo expected 3, 6", got, fq.size());
    end
    bus.flush = 1'b1;
    popped = 0;
    #1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (bus.fifo_r_en !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_r_en: cycle %0d got %b expected 1", c, bus.fifo_r_en);
      end
      if (c >= 1) begin
        vectors++;
        if (bus.m_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_valid: cycle %0d got %b expected 0", c, bus.m_valid);
        end
      end
      cycle();
    end
    vectors++;
    if (popped != 4 || fq.size() != 2) begin
      miscompares++;
      $display("FAIL flush_pops: got %0d pops, %0d left expected 4, 2", popped, fq.size());
    end
    bus.flush = 1'b0;
    exp_beat = 0;
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h61 + i));
    drive_fifo();
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_after_valid: got %b expected 0", bus.m_valid);
    end
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      if (bus.m_valid === 1'b1) begin
        exp_w = (got < 2) ? 8'(8'h56 + got) : 8'(8'h61 + got - 2);
        exp_last = LAST_EN && (got == 7);
        vectors++;
        if (bus.m_data !== exp_w || bus.m_last !== exp_last) begin
          miscompares++;
          $display("FAIL flush_post: beat %0d got %h/%b expected %h/%b", got, bus.m_data, bus.m_last, exp_w, exp_last);
        end
        got++;
      end
      cycle();
    end
    vectors++;
    if (got != 8 || bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_post_count: got %0d beats valid=%b expected 8, 0", got, bus.m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_gaps();
    test_mid_reset();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
